// File: rtl/traffic_phase_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_phase_ctrl
// Phase sequencer for a two-road traffic light. It steps through the ring
// AR_A -> G1 -> Y1 -> AR_B -> G2 -> Y2 -> AR_A. In each ring phase it first
// issues a one-cycle start pulse with the phase duration to the countdown
// timer (ISSUE), then waits for the timer's done flag (WAIT). A manual hold
// freezes the sequence and pauses the timer. An emergency request forces all
// red, and on release the ring restarts with a fresh all-red clearance.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   ihand        manual hold (synchronous, debounced)
//   iemerg       emergency all-red request (synchronous, debounced)
//   tmr_done     timer done flag, level
//   tmr_enable   timer enable (low while held or in emergency)
//   tmr_start    timer start, one-cycle pulse
//   tmr_goal     timer duration in seconds for the current phase
//   r1, y1, g1   road-1 lamps, active-high
//   r2, y2, g2   road-2 lamps, active-high
//   phase        current phase code for the seven-segment display
// -----------------------------------------------------------------------------
module traffic_phase_ctrl #(
  parameter int unsigned G1_SEC = 5,
  parameter int unsigned G2_SEC = 4,
  parameter int unsigned Y_SEC  = 2,
  parameter int unsigned AR_SEC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ihand,
  input  logic       iemerg,
  input  logic       tmr_done,
  output logic       tmr_enable,
  output logic       tmr_start,
  output logic [2:0] tmr_goal,
  output logic       r1,
  output logic       y1,
  output logic       g1,
  output logic       r2,
  output logic       y2,
  output logic       g2,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    PH_AR_A  = 3'd0,
    PH_G1    = 3'd1,
    PH_Y1    = 3'd2,
    PH_AR_B  = 3'd3,
    PH_G2    = 3'd4,
    PH_Y2    = 3'd5,
    PH_EMERG = 3'd6
  } phase_e;

  typedef enum logic {
    SUB_ISSUE = 1'b0,
    SUB_WAIT  = 1'b1
  } sub_e;

  phase_e phase_q, phase_d;
  sub_e   sub_q, sub_d;

  // True for the six phases that take part in the timed ring.
  function automatic logic is_ring(input phase_e p);
    case (p)
      PH_AR_A, PH_G1, PH_Y1, PH_AR_B, PH_G2, PH_Y2: is_ring = 1'b1;
      default:                                      is_ring = 1'b0;
    endcase
  endfunction

  // Successor in the ring; anything unexpected restarts at AR_A.
  function automatic phase_e ring_next(input phase_e p);
    case (p)
      PH_AR_A: ring_next = PH_G1;
      PH_G1:   ring_next = PH_Y1;
      PH_Y1:   ring_next = PH_AR_B;
      PH_AR_B: ring_next = PH_G2;
      PH_G2:   ring_next = PH_Y2;
      PH_Y2:   ring_next = PH_AR_A;
      default: ring_next = PH_AR_A;
    endcase
  endfunction

  // Timer duration for each phase; emergency carries no duration.
  function automatic logic [2:0] goal_of(input phase_e p);
    case (p)
      PH_AR_A, PH_AR_B: goal_of = 3'(AR_SEC);
      PH_G1:            goal_of = 3'(G1_SEC);
      PH_G2:            goal_of = 3'(G2_SEC);
      PH_Y1, PH_Y2:     goal_of = 3'(Y_SEC);
      default:          goal_of = 3'd0;
    endcase
  endfunction

  // State register: phase and ISSUE/WAIT sub-state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= PH_AR_A;
      sub_q   <= SUB_ISSUE;
    end else begin
      phase_q <= phase_d;
      sub_q   <= sub_d;
    end
  end

  // Next-state logic. Priority: emergency, leaving emergency, hold, sequencing.
  always_comb begin
    phase_d = phase_q;
    sub_d   = sub_q;
    if (iemerg) begin
      phase_d = PH_EMERG;
      sub_d   = SUB_ISSUE;
    end else if (!is_ring(phase_q)) begin
      // Leaving emergency always goes through a fresh all-red clearance,
      // even when hold is active; the start is then withheld in ISSUE.
      phase_d = PH_AR_A;
      sub_d   = SUB_ISSUE;
    end else if (ihand) begin
      phase_d = phase_q;
      sub_d   = sub_q;
    end else if (sub_q == SUB_ISSUE) begin
      // Done is ignored here: the timer clears it on the edge that
      // captures start, so any done seen now is stale.
      sub_d = SUB_WAIT;
    end else if (tmr_done) begin
      phase_d = ring_next(phase_q);
      sub_d   = SUB_ISSUE;
    end else begin
      phase_d = phase_q;
      sub_d   = sub_q;
    end
  end

  // Output decode of the registered state; timer controls are gated by rst
  // so that nothing reaches the timer while reset is asserted.
  always_comb begin
    r1 = 1'b1;
    y1 = 1'b0;
    g1 = 1'b0;
    r2 = 1'b1;
    y2 = 1'b0;
    g2 = 1'b0;
    case (phase_q)
      PH_G1: begin
        r1 = 1'b0;
        g1 = 1'b1;
      end
      PH_Y1: begin
        r1 = 1'b0;
        y1 = 1'b1;
      end
      PH_G2: begin
        r2 = 1'b0;
        g2 = 1'b1;
      end
      PH_Y2: begin
        r2 = 1'b0;
        y2 = 1'b1;
      end
      default: begin
        r1 = 1'b1;
        r2 = 1'b1;
      end
    endcase
    tmr_enable = rst & ~(ihand | iemerg);
    tmr_start  = rst & is_ring(phase_q) & (sub_q == SUB_ISSUE) & ~ihand & ~iemerg;
    tmr_goal   = rst ? goal_of(phase_q) : 3'd0;
    phase      = phase_q;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
Phase sequencer for the two-road traffic light. It is the initiator side of the countdown-timer handshake: it issues start/goal/enable to the timer and advances phase when the timer returns done. It drives the six lamp outputs for road 1 and road 2. It also handles a manual hold input and an emergency all-red input.

Parameters:
G1_SEC, 5, road-1 green duration in seconds; legal range 1..7, 3-bit goal.
G2_SEC, 4, road-2 green duration in seconds; legal range 1..7.
Y_SEC, 2, yellow duration in seconds, both roads; legal range 1..7.
AR_SEC, 1, all-red clearance duration in seconds; legal range 1..7.

Ports:
clk  in  1  system clock; rising edge.
rst  in  1  asynchronous active-low reset.
ihand  in  1  manual hold; synchronous to clk, already debounced upstream.
iemerg  in  1  emergency all-red request; synchronous to clk, already debounced upstream.
tmr_done  in  1  timer done flag, level.
tmr_enable  out  1  timer enable.
tmr_start  out  1  timer start, single-cycle pulse.
tmr_goal  out  3  timer duration in seconds.
r1, y1, g1  out  1 each  road-1 lamps, active-high.
r2, y2, g2  out  1 each  road-2 lamps, active-high.
phase  out  3  current phase code, for seven-segment display.

Behaviour:
- Reset (rst=0, asynchronous): phase=AR_A, sub=ISSUE.
- Outputs while rst=0: r1=r2=1, y1=g1=y2=g2=0, tmr_start=0, tmr_enable=0, tmr_goal=0, phase=0.
- Phases and codes: AR_A=0, G1=1, Y1=2, AR_B=3, G2=4, Y2=5, EMERG=6.
- Phase ring: AR_A->G1->Y1->AR_B->G2->Y2->AR_A.
- Lamp decode:
  - AR_A, AR_B, EMERG: r1=r2=1.
  - G1: g1=1, r2=1.
  - Y1: y1=1, r2=1.
  - G2: r1=1, g2=1.
  - Y2: r1=1, y2=1.
  - Exactly one lamp per road is lit at all times.
- Goal per phase: AR_*=AR_SEC, G1=G1_SEC, G2=G2_SEC, Y*=Y_SEC, EMERG=0.
- Each ring phase has two sub-states, ISSUE and WAIT.
  - ISSUE: tmr_start=1 for exactly one cycle with tmr_goal valid; next cycle sub=WAIT.
  - WAIT: tmr_start=0, tmr_goal held. When tmr_done=1 is sampled, advance to the next phase in sub=ISSUE.
  - tmr_done is ignored in ISSUE. The timer clears done on the same edge it captures start, so a stale done cannot advance the phase.
- tmr_enable = !(ihand | iemerg) whenever out of reset.
- Lamps, phase and tmr_goal are a combinational decode of the registered state.
- tmr_start = (sub==ISSUE) & !ihand & !iemerg, and only in ring phases.
- Minimum dwell per phase is 2 cycles (ISSUE plus one WAIT cycle).
- Manual hold (ihand=1, iemerg=0):
  - Phase and sub are frozen and lamps unchanged; tmr_enable=0 pauses the timer.
  - In ISSUE, start is withheld and issued on the first cycle after ihand falls.
  - tmr_done=1 in the same cycle as ihand=1 is ignored; the timer drops done when enable is 0. On release the timer resumes its remaining count and re-raises done.
- Emergency (iemerg=1):
  - Overrides hold. Next edge: phase=EMERG, all red, tmr_enable=0, tmr_start=0.
  - Phase stays EMERG while iemerg=1.
  - On the first cycle with iemerg=0, go to AR_A/ISSUE, giving a fresh all-red clearance before G1. The interrupted phase is not resumed.
- Simultaneous done and iemerg: emergency wins.
- Simultaneous done and ihand: hold wins.
- Reset mid-phase returns to AR_A asynchronously. The first start pulse occurs on the first clock edge after rst deasserts.

Test Plan:
- Reset release; the bench timer model raises done 10 cycles after start. Required: phase sequence 0,1,2,3,4,5,0. Exactly one tmr_start pulse per phase, with goals 1,5,2,1,4,2. Lamps match the decode table at every cycle.
- Hold ihand=1 for 20 cycles mid-G1 WAIT. Required: phase stays 1 and g1=1 throughout. tmr_enable=0, no start pulse, and a done asserted during the hold is ignored. After release, G1 exits on the next done.
- Pulse iemerg for 5 cycles during G2. Required: next edge phase=6, r1=r2=1, tmr_enable=0. After iemerg falls: phase=0, one start pulse with goal=1, then G1.
- Hold done=1 constantly. Required: each phase lasts exactly 2 cycles and the ring still completes in order (minimum dwell).
- Assert rst=0 asynchronously mid-Y1. Required: same cycle, r1=r2=1 and tmr_start=0. After release, phase=0 with a goal=1 start.
- Assert ihand and iemerg together during Y2. Required: EMERG entered. Releasing iemerg while ihand=1 gives AR_A with start withheld until ihand=0.
